// File: rtl/tone_sequencer.sv
// Melody step sequencer: walks a packed tone table and drives the tone-divider
// select plus an audible gate, with per-step beat duration and trailing gap.
//
// state | meaning
// IDLE  | waiting for start; outputs at rest values
// PLAY  | holding current step tone for (dur+1) beats
// GAP   | muted silence after a step, tone_sel held
module tone_sequencer #(
  parameter int CLK_HZ      = 100000000,
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int NUM_STEPS   = 8,
  parameter logic [5*NUM_STEPS-1:0] PATTERN = 40'h0044318820
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [1:0] tone_sel,
  output logic       tone_en,
  output logic       busy,
  output logic [3:0] step_idx,
  output logic       done
);

  localparam int PLAY_MAX = 4 * BEAT_CYCLES;
  localparam int CNT_MAX  = (PLAY_MAX > GAP_CYCLES) ? PLAY_MAX : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       steps [16];
  logic [3:0]       next_idx;
  logic [4:0]       next_step;
  logic             last;
  logic             advance;

  // Table padded to 16 entries so a 4-bit index always fits exactly.
  for (genvar g = 0; g < 16; g++) begin : g_steps
    if (g < NUM_STEPS) begin : g_used
      assign steps[g] = PATTERN[5*g +: 5];
    end else begin : g_unused
      assign steps[g] = 5'd0;
    end
  end

  function automatic logic [CNT_W-1:0] play_len(input logic [1:0] dur);
    return CNT_W'((int'(dur) + 1) * BEAT_CYCLES - 1);
  endfunction

  always_comb begin
    last      = (step_idx == LAST_STEP);
    next_idx  = last ? 4'd0 : step_idx + 4'd1;
    next_step = steps[next_idx];
    advance   = (cnt == '0) &&
                ((state == GAP) || ((state == PLAY) && (GAP_CYCLES == 0)));
  end

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst || stop) begin
      state    <= IDLE;
      cnt      <= '0;
      tone_sel <= 2'd0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      step_idx <= 4'd0;
    end else if (advance) begin
      if (last && !loop) begin
        state    <= IDLE;
        cnt      <= '0;
        tone_sel <= 2'd0;
        tone_en  <= 1'b0;
        busy     <= 1'b0;
        step_idx <= 4'd0;
        done     <= 1'b1;
      end else begin
        state    <= PLAY;
        step_idx <= next_idx;
        tone_sel <= next_step[1:0];
        tone_en  <= ~next_step[4];
        cnt      <= play_len(next_step[3:2]);
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= PLAY;
            busy     <= 1'b1;
            step_idx <= 4'd0;
            tone_sel <= steps[0][1:0];
            tone_en  <= ~steps[0][4];
            cnt      <= play_len(steps[0][3:2]);
          end
        end
        PLAY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Only reached with a nonzero gap; zero-gap ends go through advance.
            state   <= GAP;
            tone_en <= 1'b0;
            cnt     <= GAP_LOAD;
          end
        end
        GAP: begin
          cnt <= cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: cycle-by-cycle output checks against
// hand-derived timelines for gapped and gapless configurations.
module tb_tone_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;

  logic [1:0] tone_sel_a, tone_sel_b;
  logic       tone_en_a, tone_en_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] step_idx_a, step_idx_b;
  logic [8:0] vec_a, vec_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tone_sequencer #(
    .CLK_HZ(100), .BEAT_CYCLES(4), .GAP_CYCLES(2), .NUM_STEPS(4), .PATTERN(20'h7C0A2)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .tone_sel(tone_sel_a), .tone_en(tone_en_a), .busy(busy_a),
    .step_idx(step_idx_a), .done(done_a)
  );

  tone_sequencer #(
    .CLK_HZ(100), .BEAT_CYCLES(4), .GAP_CYCLES(0), .NUM_STEPS(4), .PATTERN(20'h7C0A2)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .tone_sel(tone_sel_b), .tone_en(tone_en_b), .busy(busy_b),
    .step_idx(step_idx_b), .done(done_b)
  );

  // {done, busy, tone_en, step_idx, tone_sel}
  assign vec_a = {done_a, busy_a, tone_en_a, step_idx_a, tone_sel_a};
  assign vec_b = {done_b, busy_b, tone_en_b, step_idx_b, tone_sel_b};

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs c cycles after the start was sampled.
  function automatic logic [8:0] exp_vec(input int c_in, input bit nogap, input bit lp);
    int         c;
    int         period;
    logic [3:0] s;
    logic [1:0] t;
    logic       en;
    c = c_in;
    period = nogap ? 32 : 40;
    s = 4'd0;
    t = 2'd0;
    en = 1'b0;
    if (lp) while (c > period) c -= period;
    if (c < 1 || c > period + 1) return 9'h000;
    if (c == period + 1) return 9'h100;
    if (nogap) begin
      if (c <= 4)       begin s = 4'd0; t = 2'd2; en = 1'b1; end
      else if (c <= 12) begin s = 4'd1; t = 2'd1; en = 1'b1; end
      else if (c <= 16) begin s = 4'd2; t = 2'd0; en = 1'b0; end
      else              begin s = 4'd3; t = 2'd3; en = 1'b1; end
    end else begin
      if (c <= 4)       begin s = 4'd0; t = 2'd2; en = 1'b1; end
      else if (c <= 6)  begin s = 4'd0; t = 2'd2; en = 1'b0; end
      else if (c <= 14) begin s = 4'd1; t = 2'd1; en = 1'b1; end
      else if (c <= 16) begin s = 4'd1; t = 2'd1; en = 1'b0; end
      else if (c <= 22) begin s = 4'd2; t = 2'd0; en = 1'b0; end
      else if (c <= 38) begin s = 4'd3; t = 2'd3; en = 1'b1; end
      else              begin s = 4'd3; t = 2'd3; en = 1'b0; end
    end
    return {1'b0, 1'b1, en, s, t};
  endfunction

  task automatic do_reset();
    start = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Pulses start, then checks cycles 1..ncyc; optional restart/stop/reset
  // pulses are driven during the given cycle and take effect at its end.
  task automatic run(input string name, input bit nogap, input bit lp, input int ncyc,
                     input int restart_at, input int stop_at, input int rst_at);
    int cut;
    cut = (stop_at > 0) ? stop_at : ((rst_at > 0) ? rst_at : 0);
    loop  = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      check($sformatf("%s_c%0d", name, c), nogap ? vec_b : vec_a,
            (cut > 0 && c > cut) ? 9'h000 : exp_vec(c, nogap, lp));
      start = (c == restart_at);
      stop  = (c == stop_at);
      rst   = (c == rst_at);
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
    loop  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("reset_a", vec_a, 9'h000);
    check("reset_b", vec_b, 9'h000);
    rst = 1'b0;
    tick();
    check("idle_a", vec_a, 9'h000);

    do_reset();
    run("single", 1'b0, 1'b0, 44, 0, 0, 0);

    do_reset();
    run("loop", 1'b0, 1'b1, 90, 0, 0, 0);

    do_reset();
    run("stop", 1'b0, 1'b0, 16, 0, 10, 0);

    do_reset();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("start_stop_c%0d", c), vec_a, 9'h000);
      tick();
    end

    do_reset();
    run("restart", 1'b0, 1'b0, 44, 3, 0, 0);

    do_reset();
    run("rst_gap", 1'b0, 1'b0, 10, 0, 0, 5);
    run("replay", 1'b0, 1'b0, 44, 0, 0, 0);

    do_reset();
    run("nogap", 1'b1, 1'b0, 36, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
